// File: rtl/tmr_vote_ctrl_if.sv
// ---------------------------------------------------------------------------
// tmr_vote_ctrl_if
// Handshake bundle between the triplicated producers, the voter and the
// single downstream consumer.
//   in_valid / in_ready : triplet handshake (producer -> voter)
//   a, b, c             : the three redundant copies of the word
//   out_valid/out_ready : result handshake (voter -> consumer)
//   vote, disagree      : voted word and per-bit disagreement mask
// master = producer/consumer side, slave = the voter.
// ---------------------------------------------------------------------------
interface tmr_vote_ctrl_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] vote;
  logic [W-1:0] disagree;

  modport master (
    output in_valid, a, b, c, out_ready,
    input  in_ready, out_valid, vote, disagree
  );

  modport slave (
    input  in_valid, a, b, c, out_ready,
    output in_ready, out_valid, vote, disagree
  );
endinterface

// File: rtl/tmr_vote_ctrl.sv
// ---------------------------------------------------------------------------
// tmr_vote_ctrl
// Bit-serial TMR voter. A triplet of W-bit words is latched, then shifted
// LSB-first through one shared 1-bit majority cell, one bit per clock. The
// voted word and a per-bit disagreement mask are assembled in place and
// presented on the result handshake. Words with any disagreement bump a
// saturating error counter.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   bus     : tmr_vote_ctrl_if.slave (input triplet + result handshakes)
//   clr_cnt : synchronous clear of err_cnt (wins over an increment)
//   err_cnt : saturating count of corrupted words
//   busy    : high while bits are being voted
// ---------------------------------------------------------------------------

// The single shared 1-bit majority cell.
module tmr_vote_major (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic maj_o
);
  assign maj_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module tmr_vote_ctrl #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  tmr_vote_ctrl_if.slave       bus,
  input  logic                 clr_cnt,
  output logic [CW-1:0]        err_cnt,
  output logic                 busy
);
  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  typedef enum logic [1:0] {IDLE, VOTE, DONE} state_t;

  state_t          state_q;
  logic [W-1:0]    a_q, b_q, c_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    vote_q, disagree_q;
  logic [CW-1:0]   err_q;

  logic            bit_maj;
  logic            bit_dis;
  logic [W-1:0]    vote_d, disagree_d;
  logic            err_inc;

  // Copies are shifted right each VOTE cycle, so bit 0 is always the bit
  // currently at position idx_q.
  tmr_vote_major u_major (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .c_i  (c_q[0]),
    .maj_o(bit_maj)
  );

  assign bit_dis = !((a_q[0] == b_q[0]) && (b_q[0] == c_q[0]));

  // Per-bit write enable: only the slot addressed by idx_q takes the new
  // result, all other slots hold.
  for (genvar gi = 0; gi < W; gi++) begin : g_slot
    assign vote_d[gi]     = (idx_q == IW'(gi)) ? bit_maj : vote_q[gi];
    assign disagree_d[gi] = (idx_q == IW'(gi)) ? bit_dis : disagree_q[gi];
  end

  // Looks at the mask including the bit being written on the final edge.
  assign err_inc = (state_q == VOTE) && (idx_q == LAST_IDX) && (|disagree_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      idx_q      <= '0;
      vote_q     <= '0;
      disagree_q <= '0;
      err_q      <= '0;
    end else begin
      if (clr_cnt) begin
        err_q <= '0;
      end else if (err_inc && (err_q != {CW{1'b1}})) begin
        err_q <= err_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            c_q        <= bus.c;
            idx_q      <= '0;
            vote_q     <= '0;
            disagree_q <= '0;
            state_q    <= VOTE;
          end
        end
        VOTE: begin
          vote_q     <= vote_d;
          disagree_q <= disagree_d;
          a_q        <= a_q >> 1;
          b_q        <= b_q >> 1;
          c_q        <= c_q >> 1;
          idx_q      <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE here means the next accept is one cycle later.
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.vote      = vote_q;
  assign bus.disagree  = disagree_q;
  assign busy          = (state_q == VOTE);
  assign err_cnt       = err_q;
endmodule

// File: tb/tb_tmr_vote_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tmr_vote_ctrl
// Directed scenarios for the bit-serial TMR voter plus a randomised run
// checked against the bitwise majority / disagreement formulas. A 2-bit
// error counter is used so that saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_tmr_vote_ctrl;
  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_cnt;
  logic [CW-1:0] err_cnt;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] err_exp;

  tmr_vote_ctrl_if #(.W(W)) bus ();

  tmr_vote_ctrl #(.W(W), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .clr_cnt(clr_cnt),
    .err_cnt(err_cnt),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Present a triplet, wait for accept, then wait for out_valid. lat counts
  // edges from the accept edge to the edge that raises out_valid. When
  // clr_at_done is set, clr_cnt is driven on the VOTE->DONE edge.
  task automatic run_word(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] cv, input bit clr_at_done,
                          output int lat);
    int n;
    n = 0;
    bus.a = av; bus.b = bv; bus.c = cv;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
      bus.in_valid = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Scramble inputs after accept; they must be ignored.
    bus.a = ~av; bus.b = ~bv; bus.c = ~cv;
    lat = 0;
    while (lat < W + 20) begin
      if (lat == W - 1) clr_cnt = clr_at_done;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      lat++;
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1", bus.out_valid);
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags: out_valid=%b busy=%b required 0 0", bus.out_valid, busy);
    end
    checks++;
    if (bus.vote !== 8'h00 || bus.disagree !== 8'h00 || err_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_values: vote=%h disagree=%h err=%0d required 00 00 0", bus.vote, bus.disagree, err_cnt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b required 1", bus.in_ready); end
    $display("reset done");
  endtask

  task automatic test_basic();
    int lat;
    run_word(8'hA5, 8'hA5, 8'hA5, 1'b0, lat);
    $display("word a=A5 b=A5 c=A5 lat=%0d vote=%h disagree=%h err=%0d", lat, bus.vote, bus.disagree, err_cnt);
    checks++;
    if (lat !== W) begin errors++; $display("FAIL basic_latency: got %0d required %0d", lat, W); end
    checks++;
    if (bus.vote !== 8'hA5) begin errors++; $display("FAIL basic_vote: got %h required a5", bus.vote); end
    checks++;
    if (bus.disagree !== 8'h00) begin errors++; $display("FAIL basic_disagree: got %h required 00", bus.disagree); end
    checks++;
    if (err_cnt !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_err_busy: err=%0d busy=%b required 0 0", err_cnt, busy);
    end
    handshake();
  endtask

  task automatic test_stall();
    int lat;
    run_word(8'hFF, 8'h0F, 8'hF0, 1'b0, lat);
    $display("word a=FF b=0F c=F0 lat=%0d vote=%h disagree=%h err=%0d", lat, bus.vote, bus.disagree, err_cnt);
    checks++;
    if (bus.vote !== 8'hFF || bus.disagree !== 8'hFF) begin
      errors++; $display("FAIL stall_result: vote=%h disagree=%h required ff ff", bus.vote, bus.disagree);
    end
    checks++;
    if (err_cnt !== 2'd1) begin errors++; $display("FAIL stall_err: got %0d required 1", err_cnt); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.vote !== 8'hFF || bus.disagree !== 8'hFF) begin
        errors++;
        $display("FAIL stall_hold_%0d: out_valid=%b in_ready=%b vote=%h disagree=%h required 1 0 ff ff",
                 i, bus.out_valid, bus.in_ready, bus.vote, bus.disagree);
      end
    end
    handshake();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_release: out_valid=%b required 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_word(8'h00, 8'h81, 8'h00, 1'b0, lat);
    $display("word a=00 b=81 c=00 lat=%0d vote=%h disagree=%h err=%0d", lat, bus.vote, bus.disagree, err_cnt);
    checks++;
    if (bus.vote !== 8'h00 || bus.disagree !== 8'h81 || err_cnt !== 2'd2) begin
      errors++; $display("FAIL b2b_result: vote=%h disagree=%h err=%0d required 00 81 2", bus.vote, bus.disagree, err_cnt);
    end
    // Next triplet already valid while the result is handed over.
    bus.a = 8'h3C; bus.b = 8'h3C; bus.c = 8'h3C;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_no_same_cycle_accept: busy=%b out_valid=%b in_ready=%b required 0 0 1",
                         busy, bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: busy=%b in_ready=%b required 1 0", busy, bus.in_ready);
    end
    lat = 0;
    while (lat < W + 20 && !bus.out_valid) begin
      @(posedge clk); #1; lat++;
    end
    $display("word a=3C b=3C c=3C lat=%0d vote=%h disagree=%h err=%0d", lat, bus.vote, bus.disagree, err_cnt);
    checks++;
    if (lat !== W || bus.vote !== 8'h3C || bus.disagree !== 8'h00 || err_cnt !== 2'd2) begin
      errors++; $display("FAIL b2b_second: lat=%0d vote=%h disagree=%h err=%0d required %0d 3c 00 2",
                         lat, bus.vote, bus.disagree, err_cnt, W);
    end
    handshake();
  endtask

  task automatic test_saturate();
    int lat;
    logic [CW-1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    checks++;
    if (err_cnt !== 2'd0) begin errors++; $display("FAIL sat_clear: got %0d required 0", err_cnt); end
    for (int i = 0; i < 5; i++) begin
      run_word(8'h12, 8'h12, 8'h13, 1'b0, lat);
      $display("word a=12 b=12 c=13 vote=%h disagree=%h err=%0d", bus.vote, bus.disagree, err_cnt);
      checks++;
      if (err_cnt !== exp_seq[i]) begin errors++; $display("FAIL sat_count_%0d: got %0d required %0d", i, err_cnt, exp_seq[i]); end
      handshake();
    end
    // Saturated at 3; a clear coinciding with the increment must leave 0.
    run_word(8'h40, 8'h00, 8'h00, 1'b1, lat);
    $display("word a=40 b=00 c=00 clr@done vote=%h disagree=%h err=%0d", bus.vote, bus.disagree, err_cnt);
    checks++;
    if (err_cnt !== 2'd0 || bus.vote !== 8'h00 || bus.disagree !== 8'h40) begin
      errors++; $display("FAIL sat_clear_wins: err=%0d vote=%h disagree=%h required 0 00 40", err_cnt, bus.vote, bus.disagree);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat;
    bus.a = 8'hFF; bus.b = 8'h00; bus.c = 8'h0F;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b required 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || err_cnt !== 2'd0) begin
      errors++; $display("FAIL mid_reset: busy=%b out_valid=%b in_ready=%b err=%0d required 0 0 0 0",
                         busy, bus.out_valid, bus.in_ready, err_cnt);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b required 1", bus.in_ready); end
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_output_%0d: out_valid=%b required 0", i, bus.out_valid); end
    end
    run_word(8'h3C, 8'h3C, 8'hC3, 1'b0, lat);
    $display("word a=3C b=3C c=C3 after reset vote=%h disagree=%h err=%0d", bus.vote, bus.disagree, err_cnt);
    checks++;
    if (lat !== W || bus.vote !== 8'h3C || bus.disagree !== 8'hFF || err_cnt !== 2'd1) begin
      errors++; $display("FAIL mid_fresh_word: lat=%0d vote=%h disagree=%h err=%0d required %0d 3c ff 1",
                         lat, bus.vote, bus.disagree, err_cnt, W);
    end
    handshake();
  endtask

  task automatic test_random();
    int lat;
    int stall;
    logic [W-1:0] ra, rb, rc, ev, ed;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    err_exp = '0;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = W'($urandom);
      // Bias toward agreement so both clean and corrupted words appear.
      if ($urandom_range(0, 2) == 0) begin rb = ra; rc = ra; end
      ev = (ra & rb) | (ra & rc) | (rb & rc);
      ed = ~((ra ~^ rb) & (rb ~^ rc));
      if (ed != '0 && err_exp != {CW{1'b1}}) err_exp = err_exp + 1'b1;
      run_word(ra, rb, rc, 1'b0, lat);
      stall = $urandom_range(0, 3);
      repeat (stall) begin @(posedge clk); #1; end
      $display("rand %0d a=%h b=%h c=%h vote=%h disagree=%h err=%0d", i, ra, rb, rc, bus.vote, bus.disagree, err_cnt);
      checks++;
      if (bus.vote !== ev || bus.disagree !== ed || err_cnt !== err_exp || lat !== W) begin
        errors++;
        $display("FAIL rand_%0d: vote=%h disagree=%h err=%0d lat=%0d required %h %h %0d %0d",
                 i, bus.vote, bus.disagree, err_cnt, lat, ev, ed, err_exp, W);
      end
      handshake();
    end
  endtask

  initial begin
    rst = 1'b1;
    clr_cnt = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0;
    err_exp = '0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
